// File: rtl/instruction_decode_stage_if.sv
// Bus bundle for instruction_decode_stage: instruction input handshake and
// decoded-field output handshake.
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both 1. A source that raises valid keeps valid and
// its payload stable until that transfer. Ready is allowed to depend only on
// registered state of the sink.
interface instruction_decode_stage_if #(
    parameter int GROUP_W = 3,
    parameter int CMD_W   = 3,
    parameter int ARG_W   = 8,
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [GROUP_W-1:0] command_group;
    logic [CMD_W-1:0]   command;
    logic [ARG_W-1:0]   arg1;
    logic [ARG_W-1:0]   arg2;
    logic [ADDR_W-1:0]  address;
    logic               out_illegal;

    // Decode stage side.
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, command_group, command, arg1, arg2,
               address, out_illegal
    );

    // Fetch / control-unit side.
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, command_group, command, arg1, arg2,
               address, out_illegal
    );
endinterface

// File: rtl/instruction_decode_stage.sv
// Registered instruction decode stage. Splits an instruction word into
// command_group | command | pad0 | arg1 | pad1 | arg2 | address, holding the
// word in an output register (M) backed by a one-entry skid register (S) so
// in_ready never depends combinationally on out_ready.
// Optional macro DECODE_ILLEGAL_CHECK_EN: when defined, out_illegal flags a set
// pad bit or an all-ones command_group; otherwise out_illegal is tied 0.
module instruction_decode_stage #(
    parameter int GROUP_W = 3,
    parameter int CMD_W   = 3,
    parameter int ARG_W   = 8,
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    instruction_decode_stage_if.slave bus,
    output logic [CNT_W-1:0]         decode_count
);
    localparam int PAD0 = INSTR_W - GROUP_W - CMD_W - 1;
    localparam int PAD1 = ARG_W + ADDR_W;

    generate
        if (INSTR_W != GROUP_W + CMD_W + 2 * ARG_W + ADDR_W + 2) begin : g_bad_width
            $error("instruction_decode_stage: INSTR_W does not match field widths");
        end
    endgenerate

    logic [INSTR_W-1:0] m_word, m_word_d;
    logic [INSTR_W-1:0] s_word, s_word_d;
    logic               m_valid, m_valid_d;
    logic               s_valid, s_valid_d;
    logic               in_fire, out_fire;

    assign bus.in_ready  = !s_valid;
    assign bus.out_valid = m_valid;
    assign in_fire  = bus.in_valid & !s_valid;
    assign out_fire = m_valid & bus.out_ready;

    // Next-state of the M/S pair; flush wins, then drain S into M on completion.
    always_comb begin
        m_word_d  = m_word;
        m_valid_d = m_valid;
        s_word_d  = s_word;
        s_valid_d = s_valid;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (out_fire) begin
            if (s_valid) begin
                m_word_d  = s_word;
                s_valid_d = 1'b0;
            end else if (in_fire) begin
                m_word_d  = bus.in_instr;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (!m_valid) begin
            if (in_fire) begin
                m_word_d  = bus.in_instr;
                m_valid_d = 1'b1;
            end
        end else if (in_fire) begin
            s_word_d  = bus.in_instr;
            s_valid_d = 1'b1;
        end
    end

    // Storage registers; words are kept when invalid so fields hold their last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_word  <= '0;
            m_valid <= 1'b0;
            s_word  <= '0;
            s_valid <= 1'b0;
        end else begin
            m_word  <= m_word_d;
            m_valid <= m_valid_d;
            s_word  <= s_word_d;
            s_valid <= s_valid_d;
        end
    end

    // Retired-decode counter; counts output completions even in a flush cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            decode_count <= '0;
        end else if (out_fire) begin
            decode_count <= decode_count + CNT_W'(1);
        end
    end

    assign bus.command_group = m_word[INSTR_W-1 -: GROUP_W];
    assign bus.command       = m_word[INSTR_W-GROUP_W-1 -: CMD_W];
    assign bus.arg1          = m_word[PAD0-1 -: ARG_W];
    assign bus.arg2          = m_word[PAD1-1 -: ARG_W];
    assign bus.address       = m_word[ADDR_W-1:0];

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic m_illegal;

    function automatic logic is_illegal(input logic [INSTR_W-1:0] w);
        return w[PAD0] | w[PAD1] | (&w[INSTR_W-1 -: GROUP_W]);
    endfunction

    // Advisory flag registered with M; forced low whenever M becomes empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_illegal <= 1'b0;
        end else begin
            m_illegal <= m_valid_d & is_illegal(m_word_d);
        end
    end

    assign bus.out_illegal = m_illegal;
`else
    logic unused_pads;
    assign unused_pads     = m_word[PAD0] ^ m_word[PAD1];
    assign bus.out_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_decode_stage.sv
// Testbench for instruction_decode_stage (default widths, plus a CNT_W=4
// instance for counter wrap). Reference model: a queue of accepted words whose
// length gives occupancy; fields are derived from the head word by shifts/masks.
module tb_instruction_decode_stage;
    localparam int GROUP_W = 3;
    localparam int CMD_W   = 3;
    localparam int ARG_W   = 8;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        flush;
    logic        flush_w;
    logic [15:0] decode_count;
    logic [3:0]  decode_count_w;

    instruction_decode_stage_if #(GROUP_W, CMD_W, ARG_W, ADDR_W, INSTR_W) bus ();
    instruction_decode_stage_if #(GROUP_W, CMD_W, ARG_W, ADDR_W, INSTR_W) bus_w ();

    instruction_decode_stage #(
        .GROUP_W(GROUP_W), .CMD_W(CMD_W), .ARG_W(ARG_W), .ADDR_W(ADDR_W),
        .INSTR_W(INSTR_W), .CNT_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus),
        .decode_count(decode_count)
    );

    instruction_decode_stage #(
        .GROUP_W(GROUP_W), .CMD_W(CMD_W), .ARG_W(ARG_W), .ADDR_W(ADDR_W),
        .INSTR_W(INSTR_W), .CNT_W(4)
    ) dut_wrap (
        .clk(clk), .reset_n(reset_n), .flush(flush_w), .bus(bus_w),
        .decode_count(decode_count_w)
    );

    // ---------------- scoreboard ----------------
    logic [INSTR_W-1:0] exp_q[$];
    logic [15:0]        exp_count;
    int                 checks = 0;
    int                 errors = 0;

    function automatic logic [29:0] exp_fields(input logic [31:0] w);
        logic [31:0] g, c, a1, a2, ad;
        g  = w >> 29;
        c  = (w >> 26) & 32'h7;
        a1 = (w >> 17) & 32'hFF;
        a2 = (w >> 8) & 32'hFF;
        ad = w & 32'hFF;
        return {g[2:0], c[2:0], a1[7:0], a2[7:0], ad[7:0]};
    endfunction

    function automatic logic exp_illegal(input logic [31:0] w);
`ifdef DECODE_ILLEGAL_CHECK_EN
        return (((w >> 25) & 32'h1) != 0) || (((w >> 16) & 32'h1) != 0) || ((w >> 29) == 32'h7);
`else
        return (w == w) ? 1'b0 : 1'b1;
`endif
    endfunction

    function automatic logic [29:0] dut_fields();
        return {bus.command_group, bus.command, bus.arg1, bus.arg2, bus.address};
    endfunction

    // ---------------- driver ----------------
    // One clock: model applies the handshakes the current inputs imply.
    task automatic tick(output logic acc);
        logic cmp;
        acc = bus.in_valid && (exp_q.size() < 2) && !flush;
        cmp = (exp_q.size() > 0) && bus.out_ready;
        @(posedge clk);
        if (cmp) exp_count = exp_count + 16'd1;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (cmp) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(bus.in_instr);
        end
        #1;
    endtask

    task automatic drain();
        logic a;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        flush         = 1'b0;
        repeat (3) tick(a);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n        = 1'b0;
        flush          = 1'b0;
        flush_w        = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_instr   = 32'hFFFF_FFFF;
        bus.out_ready  = 1'b1;
        bus_w.in_valid = 1'b0;
        bus_w.in_instr = '0;
        bus_w.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, want 0/1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (decode_count !== 16'd0 || dut_fields() !== 30'd0 || bus.out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_fields: count=%0d fields=%h illegal=%b, want 0", decode_count, dut_fields(), bus.out_illegal);
        end
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        exp_q.delete();
        exp_count = 16'd0;
    endtask

    task automatic test_single_decode();
        logic a;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h5A5A_C3E1;
        bus.out_ready = 1'b1;
        tick(a);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.command_group !== 3'b010 || bus.command !== 3'b110 ||
            bus.arg1 !== 8'h2D || bus.arg2 !== 8'hC3 || bus.address !== 8'hE1) begin
            errors++;
            $display("FAIL single_fields: v=%b grp=%b cmd=%b a1=%h a2=%h ad=%h, want 1 010 110 2d c3 e1",
                     bus.out_valid, bus.command_group, bus.command, bus.arg1, bus.arg2, bus.address);
        end
        tick(a);
        checks++;
        if (decode_count !== 16'd1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_count: count=%0d out_valid=%b, want 1/0", decode_count, bus.out_valid);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] words[4];
        logic [15:0] count_start;
        logic        a;
        int          idx = 0;
        int          got = 0;
        drain();
        count_start = exp_count;
        foreach (words[i]) words[i] = $urandom;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = words[idx];
            tick(a);
            if (a) idx++;
        end
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || dut_fields() !== exp_fields(words[0])) begin
            errors++;
            $display("FAIL bp_hold: in_ready=%b out_valid=%b fields=%h, want 0/1/%h",
                     bus.in_ready, bus.out_valid, dut_fields(), exp_fields(words[0]));
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            bus.in_valid = (idx < 4);
            if (idx < 4) bus.in_instr = words[idx];
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (dut_fields() !== exp_fields(words[got])) begin
                    errors++;
                    $display("FAIL bp_order word %0d: fields=%h, want %h", got, dut_fields(), exp_fields(words[got]));
                end
                got++;
            end
            tick(a);
            if (a) idx++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got !== 4 || decode_count !== count_start + 16'd4) begin
            errors++;
            $display("FAIL bp_total: delivered=%0d count=%0d, want 4/%0d", got, decode_count, count_start + 16'd4);
        end
    endtask

    task automatic test_flush();
        logic [15:0] count_before;
        logic        a;
        drain();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (2) begin
            bus.in_instr = $urandom;
            tick(a);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_fill: in_ready=%b out_valid=%b, want 0/1", bus.in_ready, bus.out_valid);
        end
        count_before = exp_count;
        flush        = 1'b1;
        bus.in_instr = $urandom;
        tick(a);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: out_valid=%b in_ready=%b illegal=%b, want 0/1/0",
                     bus.out_valid, bus.in_ready, bus.out_illegal);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(a);
            checks++;
            if (bus.out_valid !== 1'b0 || decode_count !== count_before) begin
                errors++;
                $display("FAIL flush_ghost cycle %0d: out_valid=%b count=%0d, want 0/%0d", c, bus.out_valid, decode_count, count_before);
            end
        end
        // A handshake completing in the flush cycle is still counted.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = $urandom;
        tick(a);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        tick(a);
        flush = 1'b0;
        checks++;
        if (decode_count !== count_before + 16'd1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_count: count=%0d out_valid=%b, want %0d/0", decode_count, bus.out_valid, count_before + 16'd1);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] words[3];
        logic [2:0]  want;
        logic        a;
        words[0] = 32'h0001_0000;
        words[1] = 32'h0000_0000;
        words[2] = 32'hE000_0000;
`ifdef DECODE_ILLEGAL_CHECK_EN
        want = 3'b101;
`else
        want = 3'b000;
`endif
        drain();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_instr  = words[i];
            bus.out_ready = 1'b1;
            tick(a);
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_illegal !== want[i]) begin
                errors++;
                $display("FAIL illegal word %h: out_valid=%b illegal=%b, want 1/%b", words[i], bus.out_valid, bus.out_illegal, want[i]);
            end
            tick(a);
        end
    endtask

    task automatic test_random();
        logic acc = 1'b1;
        drain();
        for (int c = 0; c < 400; c++) begin
            if (!(bus.in_valid && !acc)) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_instr = $urandom;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 24) == 0);
            tick(acc);
            checks++;
            if (bus.out_valid !== (exp_q.size() > 0) || bus.in_ready !== (exp_q.size() < 2)) begin
                errors++;
                $display("FAIL rnd_handshake cycle %0d: out_valid=%b in_ready=%b, want %b/%b",
                         c, bus.out_valid, bus.in_ready, exp_q.size() > 0, exp_q.size() < 2);
            end
            checks++;
            if (decode_count !== exp_count) begin
                errors++;
                $display("FAIL rnd_count cycle %0d: count=%0d, want %0d", c, decode_count, exp_count);
            end
            if (exp_q.size() > 0) begin
                checks++;
                if (dut_fields() !== exp_fields(exp_q[0]) || bus.out_illegal !== exp_illegal(exp_q[0])) begin
                    errors++;
                    $display("FAIL rnd_fields cycle %0d: fields=%h illegal=%b, want %h/%b",
                             c, dut_fields(), bus.out_illegal, exp_fields(exp_q[0]), exp_illegal(exp_q[0]));
                end
            end else begin
                checks++;
                if (bus.out_illegal !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_illegal_empty cycle %0d: illegal=%b, want 0", c, bus.out_illegal);
                end
            end
        end
        flush = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        logic a;
        drain();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h1234_5678;
        tick(a);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || decode_count !== 16'd0 || dut_fields() !== 30'd0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b count=%0d fields=%h, want 0/1/0/0",
                     bus.out_valid, bus.in_ready, decode_count, dut_fields());
        end
        exp_q.delete();
        exp_count = 16'd0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_counter_wrap();
        bus_w.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus_w.in_valid = 1'b1;
            bus_w.in_instr = $urandom;
            @(posedge clk);
            #1;
        end
        bus_w.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (decode_count_w !== 4'd1 || bus_w.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL counter_wrap: count=%0d out_valid=%b, want 1/0", decode_count_w, bus_w.out_valid);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_decode();
        test_back_pressure();
        test_flush();
        test_illegal();
        test_random();
        test_async_reset();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_decode_stage.md
Name: instruction_decode_stage

Overview:
- Registered, back-pressurable successor to the combinational instruction field splitter.
- Accepts 32-bit (parametrised) instruction words over a valid/ready handshake and splits them into command_group, command, arg1, arg2 and address fields.
- Holds the fields in an output register backed by a 1-entry skid buffer, so fetch and execute are timing-decoupled at full throughput.
- Sits between instruction memory/fetch and the CPU control unit; supports pipeline flush and counts retired decodes.

Parameters:
- GROUP_W, 3, command_group field width
- CMD_W, 3, command field width
- ARG_W, 8, width of arg1 and arg2
- ADDR_W, 8, address field width
- INSTR_W, 32, instruction width; must equal GROUP_W+CMD_W+2*ARG_W+ADDR_W+2 (elaboration error otherwise)
- CNT_W, 16, decode counter width

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous discard of all held instructions
- in_valid  input  1  upstream word valid
- in_ready  output  1  stage can accept a word
- in_instr  input  INSTR_W  instruction word
- out_valid  output  1  decoded fields valid
- out_ready  input  1  downstream accepts fields
- command_group  output  GROUP_W  decoded field
- command  output  CMD_W  decoded field
- arg1  output  ARG_W  decoded field
- arg2  output  ARG_W  decoded field
- address  output  ADDR_W  decoded field
- out_illegal  output  1  illegal-encoding flag (see Optional Feature)
- decode_count  output  CNT_W  number of completed output handshakes

Behaviour:
- Field layout, MSB to LSB: command_group | command | pad0 (1 bit) | arg1 | pad1 (1 bit) | arg2 | address. At defaults: [31:29], [28:26], pad [25], [24:17], pad [16], [15:8], [7:0].
- Storage: main output register (M) plus one skid register (S). Each holds the raw word and a valid bit. Fields are decoded from M's word, so every output is a pure slice of a register.
- Reset (async assert, sync deassert): M.valid=0, S.valid=0, decode_count=0, in_ready=1, out_valid=0, all field outputs 0, out_illegal=0.
- Handshakes:
  - in_ready = !S.valid (registered state, no combinational path from out_ready).
  - An input is accepted when in_valid & in_ready.
  - An output completes when out_valid & out_ready.
- Per-cycle update, evaluated on the state before the edge:
  - Output completes, S valid: M<=S, S emptied; an input cannot be accepted this cycle.
  - Output completes, S empty: M<=accepted input if any, else M.valid<=0.
  - No completion, M empty: M<=accepted input.
  - No completion, M full: an accepted input goes to S.
- Latency: word accepted on cycle N appears on the outputs on cycle N+1. Steady-state throughput is 1 word/cycle with out_ready held high.
- out_valid = M.valid. Fields stay stable while out_valid & !out_ready; they are held but don't-care while out_valid=0 (the last value is kept).
- Order is strictly FIFO; no word is dropped or duplicated.
- decode_count increments by 1 on each output completion and wraps 2^CNT_W-1 -> 0 with no flag. It is not affected by flush.
- flush has priority over every other event in the same cycle:
  - Next cycle: M.valid=0, S.valid=0, in_ready=1.
  - An input presented during the flush cycle is discarded.
  - An output handshake in the flush cycle still counts.
- Reset asserted mid-transfer clears all state immediately, regardless of clock.

Optional Feature:
- Macro: DECODE_ILLEGAL_CHECK_EN.
- Defined: out_illegal is registered alongside M and equals (pad0|pad1) | (command_group==all-ones). It is meaningful only when out_valid=1 and 0 when M is empty. The word still flows normally; the flag is advisory.
- Undefined: out_illegal tied 0, pad bits ignored, no extra logic.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1 -> out_valid=0, in_ready=1, decode_count=0, all fields 0.
- Single decode: in_instr=32'h5A5A_C3E1, out_ready=1 -> next cycle command_group=3'b010, command=3'b110, arg1=8'h2D, arg2=8'hC3, address=8'hE1, decode_count=1.
- Back-pressure: stream 4 words with out_ready=0 -> 2 held, in_ready=0 after the second accept. Raise out_ready -> remaining words delivered in order, none lost, decode_count=4.
- Flush: flush while M and S are full and in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed and in-flight words never appear.
- Counter wrap: CNT_W=4, 17 completed decodes -> decode_count=1.
- DECODE_ILLEGAL_CHECK_EN defined: in_instr=32'h0001_0000 (pad1 set) -> out_illegal=1. With the macro undefined -> out_illegal=0.
